// File: rtl/multiword_add_seq_pkg.sv
// Shared definitions for the multi-word add/subtract sequencer.
//   DefaultWidth    - default word width, matches the carry_select_adder datapath
//   DefaultMaxWords - default maximum number of words in one operation
//   state_e         - sequencer state: waiting for a first word, or mid-operation
package multiword_add_seq_pkg;

    localparam int unsigned DefaultWidth    = 64;
    localparam int unsigned DefaultMaxWords = 16;

    typedef enum logic {
        StIdle,
        StBusy
    } state_e;

endpackage

// File: rtl/carry_select_adder.sv
// Carry-select adder: sum/cout = a + b + cin.
// Each BLOCK-bit slice precomputes its result for carry-in 0 and 1; the ripple
// between slices is only a mux per block.
//   a, b  - operands (WIDTH bits)
//   cin   - carry in
//   sum   - result (WIDTH bits)
//   cout  - carry out of the top bit
module carry_select_adder #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned BLOCK = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned NumBlk = (WIDTH + BLOCK - 1) / BLOCK;

    logic [NumBlk:0] carry;

    assign carry[0] = cin;
    assign cout     = carry[NumBlk];

    for (genvar i = 0; i < NumBlk; i++) begin : g_blk
        localparam int unsigned Lo = i * BLOCK;
        // The top slice may be narrower when WIDTH is not a multiple of BLOCK.
        localparam int unsigned W  = (WIDTH - Lo < BLOCK) ? (WIDTH - Lo) : BLOCK;

        logic [W:0] sum0;
        logic [W:0] sum1;

        assign sum0 = {1'b0, a[Lo +: W]} + {1'b0, b[Lo +: W]};
        assign sum1 = {1'b0, a[Lo +: W]} + {1'b0, b[Lo +: W]} + {{W{1'b0}}, 1'b1};

        assign sum[Lo +: W]  = carry[i] ? sum1[W-1:0] : sum0[W-1:0];
        assign carry[i+1]    = carry[i] ? sum1[W]     : sum0[W];
    end

endmodule

// File: rtl/multiword_add_seq.sv
// Multi-precision add/subtract sequencer over one carry_select_adder.
// Operand words arrive LS word first; the carry is chained between words and
// one registered result word is emitted per accepted operand word.
//   clk, rst                     - clock, asynchronous active-high reset
//   in_valid/in_ready            - operand beat handshake
//   in_a, in_b                   - operand words
//   in_first, in_last, in_sub    - operation framing; in_sub sampled on first beats
//   out_valid/out_ready          - result beat handshake
//   out_sum, out_idx, out_last   - result word, word index, final-word flag
//   out_carry                    - carry out (NOT-borrow when subtracting)
//   out_err                      - protocol error on this beat
//   err_sticky                   - a beat was dropped since reset
module multiword_add_seq
    import multiword_add_seq_pkg::*;
#(
    parameter int unsigned WIDTH     = DefaultWidth,
    parameter int unsigned MAX_WORDS = DefaultMaxWords,
    parameter int unsigned CNT_W     = $clog2(MAX_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_first,
    input  logic             in_last,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [CNT_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_carry,
    output logic             out_err,
    output logic             err_sticky
);

    state_e             state_q, state_d;
    logic               carry_q, carry_d;
    logic               sub_q, sub_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_sum_q, out_sum_d;
    logic [CNT_W-1:0]   out_idx_q, out_idx_d;
    logic               out_last_q, out_last_d;
    logic               out_carry_q, out_carry_d;
    logic               out_err_q, out_err_d;
    logic               err_sticky_q, err_sticky_d;

    logic               accept;
    logic               sub_eff;
    logic [WIDTH-1:0]   add_b;
    logic               add_cin;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic [CNT_W-1:0]   idx;
    logic               drop;
    logic               at_max;
    logic               end_op;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Subtraction is A + ~B + 1; the +1 enters as cin on the first word only.
    assign sub_eff  = in_first ? in_sub : sub_q;
    assign add_b    = sub_eff ? ~in_b : in_b;
    assign add_cin  = in_first ? in_sub : carry_q;

    carry_select_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (in_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign idx    = in_first ? '0 : cnt_q;
    assign drop   = !in_first && (state_q == StIdle);
    assign at_max = (idx == CNT_W'(MAX_WORDS - 1));
    // Reaching the last index slot closes the operation even without in_last.
    assign end_op = in_last || at_max;

    always_comb begin
        state_d      = state_q;
        carry_d      = carry_q;
        sub_d        = sub_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_sum_d    = out_sum_q;
        out_idx_d    = out_idx_q;
        out_last_d   = out_last_q;
        out_carry_d  = out_carry_q;
        out_err_d    = out_err_q;
        err_sticky_d = err_sticky_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (drop) begin
                err_sticky_d = 1'b1;
            end else begin
                out_valid_d = 1'b1;
                out_sum_d   = add_sum;
                out_idx_d   = idx;
                out_last_d  = end_op;
                out_carry_d = add_cout;
                // Flag a truncated previous operation or a forced termination.
                out_err_d   = (in_first && (state_q == StBusy)) || (at_max && !in_last);
                carry_d     = add_cout;
                cnt_d       = idx + CNT_W'(1);
                if (in_first) begin
                    sub_d = in_sub;
                end
                state_d = end_op ? StIdle : StBusy;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            carry_q      <= 1'b0;
            sub_q        <= 1'b0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_sum_q    <= '0;
            out_idx_q    <= '0;
            out_last_q   <= 1'b0;
            out_carry_q  <= 1'b0;
            out_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            carry_q      <= carry_d;
            sub_q        <= sub_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_sum_q    <= out_sum_d;
            out_idx_q    <= out_idx_d;
            out_last_q   <= out_last_d;
            out_carry_q  <= out_carry_d;
            out_err_q    <= out_err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_sum    = out_sum_q;
    assign out_idx    = out_idx_q;
    assign out_last   = out_last_q;
    assign out_carry  = out_carry_q;
    assign out_err    = out_err_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: doc/multiword_add_seq.md
Name: multiword_add_seq

Overview:
- Sequences multi-precision (bignum) additions and subtractions over the 64-bit carry_select_adder.
- Accepts a stream of operand word pairs, least-significant word first, with valid/ready handshaking.
- Drives the adder's a/b/cin inputs and consumes its sum/cout, chaining the carry between words.
- Emits one registered result word per accepted operand word.
- Sits between the operand source (DMA/register file) and the result sink.

Parameters:
- WIDTH, 64, word width; must match the carry_select_adder width.
- MAX_WORDS, 16, maximum words per operation (≥2).
- CNT_W, $clog2(MAX_WORDS), width of the word index.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat.
- in_a  input  WIDTH  operand A word.
- in_b  input  WIDTH  operand B word.
- in_first  input  1  beat is the LS word of a new operation.
- in_last  input  1  beat is the MS word of the operation.
- in_sub  input  1  sampled on in_first beats only; 1 = A−B, 0 = A+B.
- out_valid  output  1  result beat valid.
- out_ready  input  1  sink accepts the result beat.
- out_sum  output  WIDTH  result word.
- out_idx  output  CNT_W  word index within the operation (0 = LS).
- out_last  output  1  final word of the operation.
- out_carry  output  1  adder cout for this word. On the last word: final carry-out (add) or NOT-borrow (sub).
- out_err  output  1  protocol error flagged on this beat.
- err_sticky  output  1  set on any dropped beat; cleared only by rst.

Behaviour:
- Handshakes:
  - in_ready = !out_valid || out_ready; a single output register stage gives 1-cycle latency.
  - Input accepted when in_valid && in_ready; output transferred when out_valid && out_ready.
  - Accept and transfer in the same cycle is allowed, giving full throughput of 1 word/cycle.
- State: IDLE (awaiting a first word) and BUSY (mid-operation). Registers: carry_q, sub_q, cnt_q.
- Adder drive:
  - a = in_a.
  - b = (in_first ? in_sub : sub_q) ? ~in_b : in_b.
  - cin = in_first ? in_sub : carry_q.
  - Combinational through the adder; the result is captured into the output register on accept.
- On an accepted beat:
  - carry_q ← cout.
  - If in_first: sub_q ← in_sub.
  - cnt_q ← (in_first ? 0 : cnt_q) + 1.
  - out_idx ← in_first ? 0 : cnt_q.
- Transitions:
  - IDLE + first && !last → BUSY.
  - IDLE + first && last → IDLE (single-word operation).
  - BUSY + last → IDLE.
  - BUSY + !last → BUSY.
- Boundary cases:
  - Non-first beat in IDLE: accepted and dropped, no output, err_sticky ← 1.
  - in_first while BUSY: the new operation starts (carry restarts from in_sub). That output beat has out_err = 1 to flag the truncated previous operation.
  - Word index reaches MAX_WORDS−1 without in_last: the beat is emitted with out_last = 1 and out_err = 1, state → IDLE. Following non-first beats are dropped per the IDLE rule.
  - in_first && in_last: out_last = 1, out_idx = 0.
  - in_sub is ignored on non-first beats.
  - Output stalled (out_valid && !out_ready): all output fields hold stable and in_ready = 0. carry_q/cnt_q do not advance.
- Reset (async, mid-operation allowed):
  - State → IDLE.
  - out_valid, out_sum, out_idx, out_last, out_carry, out_err, carry_q, sub_q, cnt_q, err_sticky → 0.
  - Any in-flight result is discarded.

Decomposition:
- Shared package holds:
  - state enum {IDLE, BUSY}
  - WIDTH default constant
  - MAX_WORDS default constant
- Sub-module: the existing carry_select_adder, instantiated once (a, b, cin, sum, cout).
- All sequencing, handshake and error logic stays in multiword_add_seq.

Test Plan:
- 2-word add, A = {0x0,0xFFFF_FFFF_FFFF_FFFF}, B = {0x0,0x1}, out_ready = 1 → word0 sum = 0, carry = 1; word1 sum = 1, carry = 0, out_last = 1, idx 0 then 1.
- 2-word sub, A = {0x1,0x0}, B = {0x0,0x1}, in_sub = 1 → word0 = 0xFFFF_FFFF_FFFF_FFFF, word1 = 0x0, final out_carry = 1 (no borrow).
- Backpressure: 4-word add with out_ready low for 3 cycles after word1 → in_ready = 0 during the stall, word1 held stable, sums correct, no beat lost or duplicated.
- Non-first beat in IDLE → no out_valid, err_sticky = 1. Then in_first mid-operation → out_err = 1 on the new operation's idx 0.
- MAX_WORDS = 4, feed 5 beats without in_last → beat idx 3 has out_last = 1 and out_err = 1; 5th beat dropped, err_sticky = 1.
- Assert rst while BUSY with out_valid = 1 → all outputs 0 at once. A following first+last beat 0x5+0x7 → out_sum = 0xC, idx 0.
